// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration register bank.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_cfg_pkg;

  // Frame parser states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int CMD_W  = 8;  // command byte width
  localparam int RD_BIT = 7;  // command bit selecting a read
  localparam int ADDR_W = 7;  // start address field / wr_addr width

  // Register index after a word, wrapping from n-1 back to 0
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input int n);
    return (int'(a) == n - 1) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_cfg_bank_if.sv
// SPI pins plus configuration outputs of the register bank.
// Latency: n/a (wiring only).
// Backpressure: none; SPI is master-paced, outputs are pulses/levels.
interface spi_cfg_bank_if #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16
);
  logic                          spi_clk;
  logic                          spi_mosi;
  logic                          spi_nss;
  logic                          spi_miso;
  logic                          spi_miso_oe;
  logic [NUM_REGS*REG_W-1:0]     cfg;
  logic                          wr_stb;
  logic [spi_cfg_pkg::ADDR_W-1:0] wr_addr;
  logic                          err;

  // SPI master / register consumer side
  modport master (
    output spi_clk, spi_mosi, spi_nss,
    input  spi_miso, spi_miso_oe, cfg, wr_stb, wr_addr, err
  );

  // Register bank side
  modport slave (
    input  spi_clk, spi_mosi, spi_nss,
    output spi_miso, spi_miso_oe, cfg, wr_stb, wr_addr, err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection in the clk domain.
// Latency: SYNC_STAGES clk to level, edge pulses combinational off the last two flops.
// Backpressure: none.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async input through the chain and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{IDLE_VAL}};
      r_prev <= IDLE_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
endmodule

// File: rtl/spi_cfg_bank.sv
// SPI mode-0 slave writing a bank of config registers; optional readback via SPI_CFG_READBACK_EN.
// Latency: register/wr_stb update 1 clk after the edge sampling a word's last bit.
// Backpressure: none; clk must run >= 4x SCK, words are never stalled.
module spi_cfg_bank
  import spi_cfg_pkg::*;
#(
  parameter int               NUM_REGS    = 8,
  parameter int               REG_W       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [REG_W-1:0] RST_VAL     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_cfg_bank_if.slave bus
);
  localparam int               CNT_W     = $clog2(REG_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(REG_W - 1);

  logic w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall, w_mosi;
  logic w_unused_sck_lvl, w_unused_nss_lvl, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .i_async(bus.spi_clk),
    .o_level(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_nss (
    .clk(clk), .rst_n(rst_n), .i_async(bus.spi_nss),
    .o_level(w_unused_nss_lvl), .o_rise(w_nss_rise), .o_fall(w_nss_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(bus.spi_mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

  state_t                r_state, w_next_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [REG_W-1:0]      r_shift;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_rd;
  logic                  r_oor;
  logic                  r_word_vld;
  logic [REG_W-1:0]      r_word;
  logic [ADDR_W-1:0]     r_word_addr;
  logic [REG_W-1:0]      r_regs [NUM_REGS];
  logic                  r_wr_stb;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic                  r_err;

  // Mosi is appended here so the completed byte/word is available on the sampling edge
  logic [CMD_W-1:0] w_cmd;
  logic [REG_W-1:0] w_word;
  logic             w_cmd_last, w_word_last;

  assign w_cmd       = {r_shift[CMD_W-2:0], w_mosi};
  assign w_word      = {r_shift[REG_W-2:0], w_mosi};
  assign w_cmd_last  = (r_state == ST_CMD)  && w_sck_rise && (r_bit_cnt == CMD_LAST);
  assign w_word_last = (r_state == ST_DATA) && w_sck_rise && (r_bit_cnt == WORD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: NSS rise always returns to IDLE, reads without readback are drained
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_nss_fall) w_next_state = ST_CMD;
      ST_CMD: begin
        if (w_nss_rise) w_next_state = ST_IDLE;
        else if (w_cmd_last) begin
`ifdef SPI_CFG_READBACK_EN
          w_next_state = ST_DATA;
`else
          w_next_state = w_cmd[RD_BIT] ? ST_DRAIN : ST_DATA;
`endif
        end
      end
      ST_DATA:  if (w_nss_rise) w_next_state = ST_IDLE;
      ST_DRAIN: if (w_nss_rise) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Shift in MOSI, decode the command and hand complete words to the write stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_oor       <= 1'b0;
      r_word_vld  <= 1'b0;
      r_word      <= '0;
      r_word_addr <= '0;
    end else begin
      r_word_vld <= 1'b0;
      if (r_state == ST_IDLE || r_state == ST_DRAIN || w_nss_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_shift <= w_word;
        if (w_cmd_last) begin
          r_bit_cnt <= '0;
          r_addr    <= w_cmd[ADDR_W-1:0];
          r_rd      <= w_cmd[RD_BIT];
          r_oor     <= (int'(w_cmd[ADDR_W-1:0]) >= NUM_REGS);
        end else if (w_word_last) begin
          r_bit_cnt   <= '0;
          r_word_vld  <= 1'b1;
          r_word      <= w_word;
          r_word_addr <= r_addr;
          r_addr      <= addr_inc(r_addr, NUM_REGS);
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Commit whole words: write the register and strobe, or flag an out-of-range word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_VAL;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_err    <= 1'b0;
      if (r_word_vld) begin
        if (r_oor) begin
          r_err <= 1'b1;
        end else if (!r_rd) begin
          r_wr_stb  <= 1'b1;
          r_wr_addr <= r_word_addr;
          for (int i = 0; i < NUM_REGS; i++)
            if (r_word_addr == ADDR_W'(i)) r_regs[i] <= r_word;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign bus.cfg[g*REG_W +: REG_W] = r_regs[g];
  end

  assign bus.wr_stb  = r_wr_stb;
  assign bus.wr_addr = r_wr_addr;
  assign bus.err     = r_err;

`ifdef SPI_CFG_READBACK_EN
  logic [REG_W-1:0] w_rd_val;
  logic [REG_W-1:0] r_tx;
  logic             r_miso;
  logic             r_load;

  // Readback source: addressed register, zero when the frame is out of range
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (!r_oor && r_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
  end

  // MISO shifter: reload at each word boundary, advance on synchronised SCK falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= '0;
      r_miso <= 1'b0;
      r_load <= 1'b0;
    end else if (r_state == ST_IDLE || w_nss_rise) begin
      r_tx   <= '0;
      r_miso <= 1'b0;
      r_load <= 1'b0;
    end else if (w_cmd_last || w_word_last) begin
      r_load <= 1'b1;
    end else if (w_sck_fall && r_state == ST_DATA && r_rd) begin
      if (r_load) begin
        r_miso <= w_rd_val[REG_W-1];
        r_tx   <= {w_rd_val[REG_W-2:0], 1'b0};
        r_load <= 1'b0;
      end else begin
        r_miso <= r_tx[REG_W-1];
        r_tx   <= {r_tx[REG_W-2:0], 1'b0};
      end
    end
  end

  assign bus.spi_miso    = r_miso;
  assign bus.spi_miso_oe = (r_state == ST_DATA) && r_rd;
`else
  logic w_unused_sck_fall;
  assign w_unused_sck_fall = w_sck_fall;
  assign bus.spi_miso      = 1'b0;
  assign bus.spi_miso_oe   = 1'b0;
`endif
endmodule

// File: doc/spi_cfg_bank.md
SPI_CFG_BANK -- requirements
Module: spi_cfg_bank

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, number of configuration registers (2..128).
REQ-002 The block SHALL have parameter REG_W, default 16, register width in bits; must be a multiple of 8.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SPI inputs (>=2).
REQ-004 The block SHALL have parameter RST_VAL, default 0, REG_W-bit reset value of every register.
REQ-005 The block SHALL have port clk  in  1  system clock, sole clock.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port spi_clk  in  1  SPI SCK, mode 0, asynchronous to clk.
REQ-008 The block SHALL have port spi_mosi  in  1  SPI data in.
REQ-009 The block SHALL have port spi_nss  in  1  SPI chip select, active low.
REQ-010 The block SHALL have port spi_miso  out  1  SPI data out.
REQ-011 The block SHALL have port spi_miso_oe  out  1  MISO drive enable.
REQ-012 The block SHALL have port cfg  out  NUM_REGS*REG_W  flattened register contents; register i at bits [i*REG_W +: REG_W].
REQ-013 The block SHALL have port wr_stb  out  1  one-cycle pulse on each register update.
REQ-014 The block SHALL have port wr_addr  out  7  index of the updated register, valid with wr_stb.
REQ-015 The block SHALL have port err  out  1  one-cycle pulse per out-of-range word.

Function
REQ-016 spi_clk, spi_mosi and spi_nss SHALL each pass through SYNC_STAGES flops; SCK edges are detected in the clk domain; clk >= 4x SCK is required.
REQ-017 Frame: NSS low, then 8-bit command (bit7 = read, bits6:0 = start address), then REG_W-bit words; all fields MSB first, sampled on synchronised SCK rising edge.
REQ-018 FSM states SHALL be IDLE, CMD, DATA, DRAIN; IDLE->CMD on NSS fall; CMD->DATA after 8th bit; DATA->DATA per word; any state->IDLE on NSS rise; CMD->DRAIN on a read command when readback is compiled out.
REQ-019 A completed write word SHALL update the addressed register, assert wr_stb and set wr_addr exactly 1 clk after the clk edge that samples its last bit.
REQ-020 Address SHALL auto-increment after every word, wrapping from NUM_REGS-1 to 0.
REQ-021 Start address >= NUM_REGS: every word of that frame SHALL be discarded with one err pulse per word; no register changes.
REQ-022 NSS rising mid-word or mid-command: the partial word SHALL be discarded with no wr_stb and no err; previously completed words are kept.
REQ-023 A new NSS fall SHALL restart from CMD with a cleared bit counter.
REQ-024 All registers SHALL be updated in whole words only; cfg never shows a partially shifted value.

Reset
REQ-025 On rst_n low: FSM = IDLE, registers = RST_VAL, synchronisers = idle (SCK 0, NSS 1), wr_stb = 0, wr_addr = 0, err = 0, spi_miso = 0, spi_miso_oe = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release the block waits for the next NSS fall.

Configuration
REQ-027 With SPI_CFG_READBACK_EN defined: a read command SHALL drive spi_miso_oe high while NSS is low in DATA; the addressed register is shifted out MSB first on spi_miso, changing on synchronised SCK falling edges; the address auto-increments per word; out-of-range reads return 0 and pulse err.
REQ-028 Without SPI_CFG_READBACK_EN: spi_miso and spi_miso_oe SHALL be constant 0; a read frame enters DRAIN and changes no state.

Structure
REQ-029 Package spi_cfg_pkg SHALL hold the FSM state type, CMD_W = 8, the read-bit position and ADDR_W = 7.
REQ-030 Sub-module spi_sync_edge (synchroniser plus rise/fall detect, parameter SYNC_STAGES) SHALL be instantiated for spi_clk, spi_nss and spi_mosi.

Verification (NUM_REGS=8, REG_W=16, clk = 8x SCK)
REQ-031 Write cmd 0x03, data 0xBEEF -> reg3 = 0xBEEF; one wr_stb with wr_addr = 3; other registers remain at RST_VAL.
REQ-032 Write cmd 0x07, data 0x1111, 0x2222 -> reg7 = 0x1111, reg0 = 0x2222 (wrap); two wr_stb pulses with addresses 7 then 0.
REQ-033 Write cmd 0x0A, one word -> err pulses once; no wr_stb; cfg unchanged.
REQ-034 Write cmd 0x01, 0xAAAA, then NSS high after 9 bits of the second word -> reg1 = 0xAAAA; reg2 unchanged; one wr_stb.
REQ-035 Readback build: reg5 = 0x1234, read cmd 0x85 -> MISO bits form 0x1234 and oe is high for the word; non-readback build: MISO and oe stay 0 and no register changes.
REQ-036 Assert rst_n low after 12 bits of a frame -> all registers = RST_VAL; the next complete frame writes correctly.
